// File: rtl/sobel_pkg.sv
// sobel_pkg: constants and types shared by the Sobel frame-buffer blocks.
//   IMG_WIDTH / IMG_HEIGHT : default frame geometry in pixels
//   PIX_W                  : pixel width, matches the frame-buffer BRAM word
//   FB_ADDR_W              : frame-buffer address width (2**FB_ADDR_W >= W*H)
//   reader_state_e         : frame_buffer_reader FSM encoding
package sobel_pkg;

  localparam int IMG_WIDTH  = 720;
  localparam int IMG_HEIGHT = 540;
  localparam int PIX_W      = 12;
  localparam int FB_ADDR_W  = 19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } reader_state_e;

endpackage

// File: rtl/raster_counter.sv
// raster_counter: x/y raster position plus a linear BRAM address that walks
// 0..W*H-1 and wraps back to 0 after the last pixel.
// Ports:
//   i_clk          : clock, all logic on posedge
//   i_srst         : synchronous active-high reset, zeroes the counters
//   i_clear        : synchronous clear back to pixel (0,0)
//   i_advance      : step to the next pixel in raster order
//   o_addr         : current linear address (x + y*W, kept as its own counter)
//   o_first_px     : current position is (0,0)
//   o_last_in_line : current x is W-1
//   o_last_px      : current position is (W-1,H-1)
module raster_counter #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int ADDR_W     = 19
) (
  input  logic              i_clk,
  input  logic              i_srst,
  input  logic              i_clear,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_first_px,
  output logic              o_last_in_line,
  output logic              o_last_px
);

  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [XW-1:0]     X_LAST   = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]     Y_LAST   = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0]     X_ONE    = XW'(1);
  localparam logic [YW-1:0]     Y_ONE    = YW'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [ADDR_W-1:0] r_addr;

  logic w_last_in_line;
  logic w_last_px;

  assign w_last_in_line = (r_x == X_LAST);
  assign w_last_px      = w_last_in_line && (r_y == Y_LAST);

  assign o_addr         = r_addr;
  assign o_first_px     = (r_x == '0) && (r_y == '0);
  assign o_last_in_line = w_last_in_line;
  assign o_last_px      = w_last_px;

  // The address is a plain incrementer rather than x + y*W; it wraps to 0
  // on the last pixel so W*H itself is never presented to the BRAM.
  always_ff @(posedge i_clk) begin
    if (i_srst || i_clear) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (i_advance) begin
      if (w_last_px) begin
        r_x    <= '0;
        r_y    <= '0;
        r_addr <= '0;
      end else if (w_last_in_line) begin
        r_x    <= '0;
        r_y    <= r_y + Y_ONE;
        r_addr <= r_addr + ADDR_ONE;
      end else begin
        r_x    <= r_x + X_ONE;
        r_addr <= r_addr + ADDR_ONE;
      end
    end
  end

endmodule

// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader: raster-scan read side of the Sobel frame buffer.
// On a start pulse in IDLE it walks BRAM addresses 0..W*H-1, samples the
// BRAM's combinational read data and emits one valid/ready beat per pixel
// tagged with SOF/EOL/EOF.
// Ports:
//   clock      : clock, all logic on posedge
//   reset      : synchronous active-high reset, aborts any frame in flight
//   start      : one-cycle frame request, honoured only in IDLE
//   rd_addr    : BRAM read address
//   bram_dout  : BRAM combinational read data for rd_addr
//   out_valid  : output beat valid
//   out_ready  : downstream accepts the beat when out_valid && out_ready
//   out_data   : pixel
//   out_sof    : beat is pixel (0,0)
//   out_eol    : beat is the last pixel of a line
//   out_eof    : beat is the last pixel of the frame
//   busy       : high from start acceptance until the EOF beat is accepted
//   frame_done : one-cycle pulse in the cycle after EOF acceptance
// Configuration macro FB_READER_LOOP_EN: when defined, EOF acceptance
// re-enters RUN at address 0 so frames stream back-to-back after one start.
module frame_buffer_reader #(
  parameter int IMG_WIDTH       = sobel_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT      = sobel_pkg::IMG_HEIGHT,
  parameter int BRAM_DATA_WIDTH = sobel_pkg::PIX_W,
  parameter int BRAM_ADDR_WIDTH = sobel_pkg::FB_ADDR_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  output logic [BRAM_ADDR_WIDTH-1:0] rd_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_dout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BRAM_DATA_WIDTH-1:0] out_data,
  output logic                       out_sof,
  output logic                       out_eol,
  output logic                       out_eof,
  output logic                       busy,
  output logic                       frame_done
);

  import sobel_pkg::*;

`ifdef FB_READER_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  reader_state_e r_state;

  logic w_accept;
  logic w_start_ok;
  logic w_load;
  logic w_first_px;
  logic w_last_in_line;
  logic w_last_px;

  assign w_accept   = out_valid && out_ready;
  assign w_start_ok = (r_state == ST_IDLE) && start;

  // In loop mode the EOF acceptance also loads pixel 0 of the next frame
  // (the address has already wrapped to 0), so there is no bubble between
  // frames.
  assign w_load = ((r_state == ST_RUN) && (!out_valid || out_ready)) ||
                  (LOOP_EN && (r_state == ST_DRAIN) && w_accept);

  raster_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .ADDR_W    (BRAM_ADDR_WIDTH)
  ) u_raster (
    .i_clk         (clock),
    .i_srst        (reset),
    .i_clear       (w_start_ok),
    .i_advance     (w_load),
    .o_addr        (rd_addr),
    .o_first_px    (w_first_px),
    .o_last_in_line(w_last_in_line),
    .o_last_px     (w_last_px)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      out_eof    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // Output register: capture on load, otherwise hold until accepted.
      if (w_load) begin
        out_data  <= bram_dout;
        out_sof   <= w_first_px;
        out_eol   <= w_last_in_line;
        out_eof   <= w_last_px;
        out_valid <= 1'b1;
      end else if (w_accept) begin
        out_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            busy    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_load && w_last_px) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The only beat that can be pending here is the EOF beat.
          if (w_accept) begin
            frame_done <= 1'b1;
            if (LOOP_EN) begin
              r_state <= w_last_px ? ST_DRAIN : ST_RUN;
            end else begin
              r_state <= ST_IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// tb_frame_buffer_reader: randomized scoreboard bench for frame_buffer_reader
// on a 4x3 image. Expected beats are queued when a frame is requested; a
// monitor pops and compares on every accepted beat.
module tb_frame_buffer_reader;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int DW = 12;
  localparam int AW = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sof;
    logic          eol;
    logic          eof;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] bram_dout;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sof;
  logic          out_eol;
  logic          out_eof;
  logic          busy;
  logic          frame_done;

  logic [DW-1:0] mem [16];
  assign bram_dout = mem[rd_addr];

  always #5 clk = ~clk;

  frame_buffer_reader #(
    .IMG_WIDTH      (W),
    .IMG_HEIGHT     (H),
    .BRAM_DATA_WIDTH(DW),
    .BRAM_ADDR_WIDTH(AW)
  ) dut (
    .clock     (clk),
    .reset     (reset),
    .start     (start),
    .rd_addr   (rd_addr),
    .bram_dout (bram_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .busy      (busy),
    .frame_done(frame_done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int pop_cnt = 0;
  int ready_mode = 0;
  int hold_cnt = 0;
  int start_cyc = 0;
  beat_t exp_q[$];
  int sof_cycs[$];
  int eof_cycs[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: beat i of a frame carries mem[i]; sof at 0, eol at the end of
  // every row, eof on the final pixel.
  task automatic push_frame();
    beat_t b;
    for (int i = 0; i < N; i++) begin
      b.d   = mem[i];
      b.sof = (i == 0);
      b.eol = ((i % W) == W - 1);
      b.eof = (i == N - 1);
      exp_q.push_back(b);
    end
  endtask

  // Monitor / scoreboard, sampling on the falling edge.
  logic          exp_fd = 1'b0;
  logic          stall_v = 1'b0;
  beat_t         held;
  logic [AW-1:0] held_addr;

  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      exp_fd  = 1'b0;
      stall_v = 1'b0;
    end else begin
      if (frame_done || exp_fd) chk("frame_done_timing", {31'd0, frame_done}, {31'd0, exp_fd});
      if (frame_done) done_cnt++;
      exp_fd = out_valid && out_ready && out_eof;

      if (stall_v) begin
        chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
        chk("stall_beat_stable", {16'd0, out_data, out_sof, out_eol, out_eof}, {16'd0, held});
        chk("stall_rd_addr_held", {28'd0, rd_addr}, {28'd0, held_addr});
      end

      if (int'(rd_addr) >= N) chk("rd_addr_in_range", {28'd0, rd_addr}, 32'd0);

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {20'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", {20'd0, out_data}, {20'd0, e.d});
          chk("beat_flags", {29'd0, out_sof, out_eol, out_eof}, {29'd0, e.sof, e.eol, e.eof});
        end
        pop_cnt++;
        if (out_sof) sof_cycs.push_back(cyc);
        if (out_eof) eof_cycs.push_back(cyc);
      end

      stall_v   = out_valid && !out_ready;
      held      = {out_data, out_sof, out_eol, out_eof};
      held_addr = rd_addr;
    end
  end

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (out_valid && out_eof && hold_cnt < 10) begin
          out_ready = 1'b0;
          hold_cnt++;
          chk("busy_during_eof_hold", {31'd0, busy}, 32'd1);
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
  endtask

  task automatic fill_mem(input bit ramp);
    for (int i = 0; i < 16; i++) mem[i] = ramp ? DW'(i) : DW'($urandom);
  endtask

  task automatic run_frame(input int mode, input bit ramp, input bit extra_start);
    int d0;
    int t;
    d0 = done_cnt;
    sof_cycs.delete();
    eof_cycs.delete();
    fill_mem(ramp);
    push_frame();
    ready_mode = mode;
    hold_cnt   = 0;
    start      = 1'b1;
    start_cyc  = cyc;
    tick();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("rd_addr_after_start", {28'd0, rd_addr}, 32'd0);
    t = 0;
    while (done_cnt == d0 && t < 400) begin
      tick();
      t++;
      start = (extra_start && t == 6);
    end
    start = 1'b0;
    if (t >= 400) chk("frame_timeout", 32'd1, 32'd0);
    for (int k = 0; k < 8; k++) tick();
    chk("frames_done", done_cnt - d0, 32'd1);
    chk("busy_after_frame", {31'd0, busy}, 32'd0);
    chk("valid_after_frame", {31'd0, out_valid}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("sof_count", sof_cycs.size(), 32'd1);
    if (mode == 0 && sof_cycs.size() > 0 && eof_cycs.size() > 0) begin
      chk("first_beat_latency", sof_cycs[0] - start_cyc, 32'd2);
      chk("full_rate_span", eof_cycs[0] - sof_cycs[0], N - 1);
    end
    if (mode == 3) chk("eof_hold_cycles", hold_cnt, 32'd10);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    fill_mem(1'b1);
    for (int k = 0; k < 3; k++) tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_addr", {28'd0, rd_addr}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_data_flags", {16'd0, out_data, out_sof, out_eol, out_eof}, 32'd0);
    reset = 1'b0;
    tick();

`ifdef FB_READER_LOOP_EN
    begin
      int d0;
      int t;
      d0 = done_cnt;
      sof_cycs.delete();
      eof_cycs.delete();
      fill_mem(1'b0);
      for (int f = 0; f < 4; f++) push_frame();
      ready_mode = 0;
      start      = 1'b1;
      start_cyc  = cyc;
      tick();
      start = 1'b0;
      t = 0;
      while (done_cnt - d0 < 3 && t < 400) begin
        tick();
        t++;
      end
      if (t >= 400) chk("loop_timeout", 32'd1, 32'd0);
      chk("loop_frames_done", done_cnt - d0, 32'd3);
      chk("loop_busy", {31'd0, busy}, 32'd1);
      chk("loop_sof_count_ge3", {31'd0, sof_cycs.size() >= 3}, 32'd1);
      if (sof_cycs.size() >= 3 && eof_cycs.size() >= 3) begin
        chk("loop_first_latency", sof_cycs[0] - start_cyc, 32'd2);
        chk("loop_no_bubble", eof_cycs[2] - sof_cycs[0], 3 * N - 1);
        chk("loop_frame2_sof", sof_cycs[1] - sof_cycs[0], N);
      end
      reset = 1'b1;
      exp_q.delete();
      tick();
      chk("loop_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("loop_rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      tick();
    end
`else
    // Ramp image at full rate.
    run_frame(0, 1'b1, 1'b0);
    // 1,0,0,1 backpressure with random pixels.
    run_frame(1, 1'b0, 1'b0);
    // Random backpressure with an ignored start mid-frame.
    run_frame(2, 1'b0, 1'b1);
    // EOF beat held for 10 cycles.
    run_frame(3, 1'b0, 1'b0);

    // Reset after beat 5 aborts the frame.
    begin
      int p0;
      int d0;
      int t;
      fill_mem(1'b0);
      push_frame();
      ready_mode = 0;
      p0 = pop_cnt;
      d0 = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      t = 0;
      while (pop_cnt - p0 < 6 && t < 100) begin
        tick();
        t++;
      end
      if (t >= 100) chk("reset_test_timeout", 32'd1, 32'd0);
      reset = 1'b1;
      exp_q.delete();
      tick();
      chk("abort_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_rd_addr", {28'd0, rd_addr}, 32'd0);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      chk("abort_no_frame_done", done_cnt - d0, 32'd0);
      chk("abort_no_beats", pop_cnt - p0, 32'd6);
    end

    // Restart after the abort begins at pixel 0 with sof.
    run_frame(0, 1'b0, 1'b0);
    for (int r = 0; r < 2; r++) run_frame(2, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
